stopwatch_core: RTL and testbench

- Downstream consumer of the clock divider's toggling output.
- Detects each rising edge of the divided square wave (one edge per second at 100 MHz) and advances an MM:SS BCD stopwatch.
- Supports run/pause, clear and a manual adjust mode.
- BCD digits feed the seven-segment display multiplexer.

---
 rtl/stopwatch_core.sv | 166 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch advanced by rising edges of the clock
// divider's toggling output. Supports run/pause, clear and a manual adjust
// mode that steps either the seconds or the minutes field.
//
// Optional build feature, macro STOPWATCH_BLINK_EN:
//   defined   - in ADJUST the two digit_blank bits of the selected field
//               follow tick_q so the field being edited blinks.
//   undefined - digit_blank is tied to 4'b0000.
//
// The FSM state is held in the internal signal 'state' for checker binding.
// There is no valid/ready handshake in this block: pause_btn and clear_btn
// are single-cycle pulses, adj/sel are levels, and tick_in is a free-running
// square wave whose rising edges are the count events.

module stopwatch_core #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       wrap,
    output logic [3:0] digit_blank
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSE  = 2'd2;
    localparam logic [1:0] S_ADJUST = 2'd3;

    // BCD image of the highest legal minute value
    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

    logic [1:0] state, state_d;
    logic       tick_q;
    logic       tick_edge;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       wrap_d;
    logic       min_at_max;

    assign tick_edge  = tick_in & ~tick_q;
    assign min_at_max = (min_tens == MAX_T) && (min_ones == MAX_O);

    // Next-state selection: clear beats adj, adj beats pause_btn
    always_comb begin
        state_d = state;
        if (clear_btn) begin
            state_d = adj ? S_ADJUST : S_IDLE;
        end else if (adj) begin
            state_d = S_ADJUST;
        end else if (state == S_ADJUST) begin
            state_d = S_PAUSE;
        end else if (pause_btn) begin
            case (state)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = state;
            endcase
        end
    end

    // Digit arithmetic; the increment decision looks at the current state
    always_comb begin
        min_tens_d = min_tens;
        min_ones_d = min_ones;
        sec_tens_d = sec_tens;
        sec_ones_d = sec_ones;
        wrap_d     = 1'b0;
        if (clear_btn) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (tick_edge && state == S_RUN) begin
            if (sec_ones != 4'd9) begin
                sec_ones_d = sec_ones + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens != 4'd5) begin
                    sec_tens_d = sec_tens + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_at_max) begin
                        min_tens_d = 4'd0;
                        min_ones_d = 4'd0;
                        wrap_d     = 1'b1;
                    end else if (min_ones == 4'd9) begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens + 4'd1;
                    end else begin
                        min_ones_d = min_ones + 4'd1;
                    end
                end
            end
        end else if (tick_edge && state == S_ADJUST) begin
            if (sel) begin
                // Minutes field alone, wrapping at MAX_MIN
                if (min_at_max) begin
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                end else if (min_ones == 4'd9) begin
                    min_ones_d = 4'd0;
                    min_tens_d = min_tens + 4'd1;
                end else begin
                    min_ones_d = min_ones + 4'd1;
                end
            end else begin
                // Seconds field alone, 59 -> 00 without touching minutes
                if (sec_ones != 4'd9) begin
                    sec_ones_d = sec_ones + 4'd1;
                end else begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
                end
            end
        end
    end

    // State, digits, flags and the tick history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_q   <= 1'b1;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_d;
            tick_q   <= tick_in;
            min_tens <= min_tens_d;
            min_ones <= min_ones_d;
            sec_tens <= sec_tens_d;
            sec_ones <= sec_ones_d;
            running  <= (state_d == S_RUN);
            wrap     <= wrap_d;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    // Blink the field being adjusted at the tick rate
    always_comb begin
        digit_blank = 4'b0000;
        if (state == S_ADJUST) begin
            if (sel) digit_blank = {tick_q, tick_q, 2'b00};
            else     digit_blank = {2'b00, tick_q, tick_q};
        end
    end
`else
    // No blinking in this build
    assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed bench for stopwatch_core (MAX_MIN = 59).
module tb_stopwatch_core;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       pause_btn;
    logic       clear_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic       wrap;
    logic [3:0] digit_blank;

    int checks   = 0;
    int failures = 0;

    stopwatch_core #(.MAX_MIN(59)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .pause_btn   (pause_btn),
        .clear_btn   (clear_btn),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .wrap        (wrap),
        .digit_blank (digit_blank)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- driver tasks ----
    // advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            step(1);
            tick_in = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_pause();
        pause_btn = 1'b1;
        step(1);
        pause_btn = 1'b0;
    endtask

    // ---- comparison helpers ----
    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // expected blink mask for the current build
    function automatic logic [3:0] exp_blank(input logic in_adj, input logic s, input logic tq);
`ifdef STOPWATCH_BLINK_EN
        if (!in_adj) return 4'b0000;
        return s ? {tq, tq, 2'b00} : {2'b00, tq, tq};
`else
        return 4'b0000 & {in_adj, s, tq, 1'b0};
`endif
    endfunction

    // ---- directed sequence ----
    initial begin
        rst = 1'b1; tick_in = 1'b1; pause_btn = 1'b0; clear_btn = 1'b0;
        adj = 1'b0; sel = 1'b0;
        step(3);
        check16("reset_digits", digits(), 16'h0000);
        check1("reset_running", running, 1'b0);
        check1("reset_wrap", wrap, 1'b0);
        check16("reset_blank", {12'h000, digit_blank}, 16'h0000);

        // release with tick_in held high: no edge, no count
        rst = 1'b0;
        step(10);
        check16("hold_high_digits", digits(), 16'h0000);
        check1("hold_high_running", running, 1'b0);
        tick_in = 1'b0;
        step(1);

        // start, 61 edges -> 01:01
        pulse_pause();
        check1("start_running", running, 1'b1);
        edges(61);
        check16("run61_digits", digits(), 16'h0101);
        check1("run61_running", running, 1'b1);
        pulse_pause();
        check1("pause_running", running, 1'b0);
        edges(5);
        check16("paused_hold", digits(), 16'h0101);

        // preload 59:58 through adjust
        adj = 1'b1; sel = 1'b1;
        step(1);
        check1("adj_running", running, 1'b0);
        edges(58);
        check16("adj_min59", digits(), 16'h5901);
        sel = 1'b0;
        edges(57);
        check16("adj_5958", digits(), 16'h5958);
        adj = 1'b0;
        step(1);
        check16("exit_adj_hold", digits(), 16'h5958);
        pulse_pause();
        check1("resume_running", running, 1'b1);
        edges(1);
        check16("at_5959", digits(), 16'h5959);
        check1("no_wrap_5959", wrap, 1'b0);
        tick_in = 1'b1;
        step(1);
        check16("wrap_digits", digits(), 16'h0000);
        check1("wrap_pulse", wrap, 1'b1);
        check1("wrap_running", running, 1'b1);
        tick_in = 1'b0;
        step(1);
        check1("wrap_one_cycle", wrap, 1'b0);

        // clear collides with a tick edge at 00:07
        edges(7);
        check16("at_0007", digits(), 16'h0007);
        clear_btn = 1'b1; tick_in = 1'b1;
        step(1);
        check16("clear_digits", digits(), 16'h0000);
        check1("clear_running", running, 1'b0);
        clear_btn = 1'b0; tick_in = 1'b0;
        step(1);
        edges(2);
        check16("idle_no_count", digits(), 16'h0000);

        // adjust minutes through the MAX_MIN wrap
        adj = 1'b1; sel = 1'b1;
        step(1);
        edges(59);
        check16("adj_min_59", digits(), 16'h5900);
        tick_in = 1'b1;
        step(1);
        check16("adj_min_wrap", digits(), 16'h0000);
        check1("adj_no_wrap_pulse", wrap, 1'b0);
        check16("blank_min_hi", {12'h000, digit_blank}, {12'h000, exp_blank(1'b1, 1'b1, 1'b1)});
        tick_in = 1'b0;
        step(1);
        edges(1);
        check16("adj_min_01", digits(), 16'h0100);

        // adjust seconds, checking the blink mask on both tick phases
        sel = 1'b0;
        edges(2);
        tick_in = 1'b1;
        step(1);
        check16("adj_0103", digits(), 16'h0103);
        check16("blank_sec_hi", {12'h000, digit_blank}, {12'h000, exp_blank(1'b1, 1'b0, 1'b1)});
        tick_in = 1'b0;
        step(1);
        check16("blank_sec_lo", {12'h000, digit_blank}, {12'h000, exp_blank(1'b1, 1'b0, 1'b0)});

        // leave adjust into PAUSE, then run one more second
        adj = 1'b0;
        step(1);
        check1("adj_exit_running", running, 1'b0);
        check16("adj_exit_digits", digits(), 16'h0103);
        check16("blank_outside_adj", {12'h000, digit_blank}, 16'h0000);
        pulse_pause();
        edges(1);
        check16("run_after_adj", digits(), 16'h0104);
        check1("run_after_adj_running", running, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
